// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, CRC constants and byte-wise CRC helpers.
// Used by both the receive and transmit packet engines.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_PING  = 4'h4;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;
  localparam logic [3:0] PID_PRE   = 4'hC;
  localparam logic [3:0] PID_SPLIT = 4'h8;

  localparam logic [4:0]  CRC5_POLY   = 5'h05;
  localparam logic [4:0]  CRC5_INIT   = 5'h1F;
  localparam logic [4:0]  CRC5_RESID  = 5'b01100;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_HSHAKE,
    ST_DROP,
    ST_DONE
  } rx_state_e;

  typedef enum logic [1:0] {
    K_NONE,
    K_TOKEN,
    K_DATA,
    K_HSHAKE
  } pid_kind_e;

  function automatic pid_kind_e pid_kind(input logic [3:0] pid);
    pid_kind_e k;
    case (pid)
      PID_OUT, PID_IN, PID_SETUP,
      PID_PING, PID_SOF:              k = K_TOKEN;
      PID_DATA0, PID_DATA1,
      PID_DATA2, PID_MDATA:           k = K_DATA;
      PID_ACK, PID_NAK, PID_STALL,
      PID_NYET, PID_PRE, PID_SPLIT:   k = K_HSHAKE;
      default:                        k = K_NONE;
    endcase
    return k;
  endfunction

  // Bits enter LSB-first, matching wire order.
  function automatic logic [4:0] crc5_byte(
    input logic [4:0] c,
    input logic [7:0] d
  );
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[4] ^ d[i]) r = {r[3:0], 1'b0} ^ CRC5_POLY;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ CRC16_POLY;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_rx_holdback.sv
// Two-deep byte delay line: a byte leaves only once two newer bytes
// have arrived, so the trailing CRC16 pair is never released.
module usb_rx_holdback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_flush,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic [10:0] o_count
);

  logic [7:0]  r_b0;
  logic [7:0]  r_b1;
  logic [1:0]  r_fill;
  logic [7:0]  r_data;
  logic        r_valid;
  logic [10:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b0    <= '0;
      r_b1    <= '0;
      r_fill  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_valid <= 1'b0;
      if (i_clear) begin
        r_fill  <= '0;
        r_count <= '0;
      end else if (i_flush) begin
        r_fill <= '0;
      end else if (i_push) begin
        r_b0 <= i_byte;
        r_b1 <= r_b0;
        if (r_fill == 2'd2) begin
          r_data  <= r_b1;
          r_valid <= 1'b1;
          r_count <= r_count + 11'd1;
        end else begin
          r_fill <= r_fill + 2'd1;
        end
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/usb_rx_fsm.sv
// USB packet receiver: PID check, CRC5/CRC16 check, token decode and
// payload release with CRC stripping, between UTMI and the protocol engine.
module usb_rx_fsm
  import usb_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 60,
  parameter int MAX_PAYLOAD  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  utmi_rx_data,
  input  logic        utmi_rx_valid,
  input  logic        utmi_rx_active,
  input  logic        utmi_rx_error,
  output logic [3:0]  rx_pid,
  output logic        rx_pid_valid,
  output logic [10:0] rx_token,
  output logic        rx_token_valid,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic [10:0] rx_data_count,
  output logic        rx_done,
  output logic        rx_crc_ok,
  output logic        rx_err
);

  localparam int CW = $clog2(MAX_PAYLOAD + 3);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PAYLOAD + 2);

  rx_state_e   r_state, n_state;
  pid_kind_e   r_kind, n_kind;
  logic        r_active_q;
  logic        r_perr, n_perr;
  logic [CW-1:0] r_bcnt, n_bcnt;
  logic [4:0]  r_crc5, n_crc5;
  logic [15:0] r_crc16, n_crc16;
  logic [7:0]  r_tok_lo, n_tok_lo;
  logic [2:0]  r_tok_hi, n_tok_hi;
  logic [3:0]  r_pid, n_pid;
  logic        r_pid_valid, n_pid_valid;
  logic [10:0] r_token, n_token;
  logic        r_token_valid, n_token_valid;
  logic        r_done, n_done;
  logic        r_crc_ok, n_crc_ok;
  logic        r_err, n_err;

  logic        w_push;
  logic        w_flush;
  logic        w_start;
  logic        w_eop;
  logic        w_good;
  logic        w_pid_bad;
  pid_kind_e   w_kind;
  logic [7:0]  w_hb_data;
  logic        w_hb_valid;
  logic [10:0] w_hb_count;
  logic        w_unused;

  assign w_unused  = |CLK_FREQ_MHZ;
  assign w_kind    = pid_kind(utmi_rx_data[3:0]);
  assign w_pid_bad = (utmi_rx_data[7:4] != ~utmi_rx_data[3:0])
                   || (w_kind == K_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_kind        <= K_NONE;
      // Held high so a packet cut by reset is ignored until rx_active toggles.
      r_active_q    <= 1'b1;
      r_perr        <= 1'b0;
      r_bcnt        <= '0;
      r_crc5        <= CRC5_INIT;
      r_crc16       <= CRC16_INIT;
      r_tok_lo      <= '0;
      r_tok_hi      <= '0;
      r_pid         <= '0;
      r_pid_valid   <= 1'b0;
      r_token       <= '0;
      r_token_valid <= 1'b0;
      r_done        <= 1'b0;
      r_crc_ok      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= n_state;
      r_kind        <= n_kind;
      r_active_q    <= utmi_rx_active;
      r_perr        <= n_perr;
      r_bcnt        <= n_bcnt;
      r_crc5        <= n_crc5;
      r_crc16       <= n_crc16;
      r_tok_lo      <= n_tok_lo;
      r_tok_hi      <= n_tok_hi;
      r_pid         <= n_pid;
      r_pid_valid   <= n_pid_valid;
      r_token       <= n_token;
      r_token_valid <= n_token_valid;
      r_done        <= n_done;
      r_crc_ok      <= n_crc_ok;
      r_err         <= n_err;
    end
  end

  always_comb begin
    n_state       = r_state;
    n_kind        = r_kind;
    n_perr        = r_perr;
    n_bcnt        = r_bcnt;
    n_crc5        = r_crc5;
    n_crc16       = r_crc16;
    n_tok_lo      = r_tok_lo;
    n_tok_hi      = r_tok_hi;
    n_pid         = r_pid;
    n_pid_valid   = 1'b0;
    n_token       = r_token;
    n_token_valid = 1'b0;
    n_done        = 1'b0;
    n_crc_ok      = r_crc_ok;
    n_err         = r_err;
    w_push        = 1'b0;
    w_flush       = 1'b0;
    w_start       = 1'b0;
    w_eop         = 1'b0;
    w_good        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_start = utmi_rx_active & ~r_active_q;
      end
      ST_PID: begin
        if (utmi_rx_error) begin
          n_perr  = 1'b1;
          n_state = ST_DROP;
        end else if (utmi_rx_valid) begin
          if (w_pid_bad) begin
            n_perr  = 1'b1;
            n_state = ST_DROP;
          end else begin
            n_pid       = utmi_rx_data[3:0];
            n_pid_valid = 1'b1;
            n_kind      = w_kind;
            unique case (1'b1)
              (w_kind == K_TOKEN): n_state = ST_TOKEN;
              (w_kind == K_DATA):  n_state = ST_DATA;
              default:             n_state = ST_HSHAKE;
            endcase
          end
        end
      end
      ST_TOKEN: begin
        if (utmi_rx_error) begin
          n_perr  = 1'b1;
          n_state = ST_DROP;
        end else if (utmi_rx_valid) begin
          if (r_bcnt >= CW'(2)) begin
            n_perr  = 1'b1;
            n_state = ST_DROP;
          end else begin
            n_crc5 = crc5_byte(r_crc5, utmi_rx_data);
            n_bcnt = r_bcnt + CW'(1);
            if (r_bcnt == '0) n_tok_lo = utmi_rx_data;
            else              n_tok_hi = utmi_rx_data[2:0];
          end
        end
      end
      ST_DATA: begin
        if (utmi_rx_error) begin
          n_perr  = 1'b1;
          n_state = ST_DROP;
          w_flush = 1'b1;
        end else if (utmi_rx_valid) begin
          if (r_bcnt == LAST_IDX) begin
            n_perr  = 1'b1;
            n_state = ST_DROP;
            w_flush = 1'b1;
          end else begin
            n_crc16 = crc16_byte(r_crc16, utmi_rx_data);
            n_bcnt  = r_bcnt + CW'(1);
            w_push  = 1'b1;
          end
        end
      end
      ST_HSHAKE: begin
        if (utmi_rx_error || utmi_rx_valid) begin
          n_perr  = 1'b1;
          n_state = ST_DROP;
        end
      end
      ST_DROP: begin
        n_state = ST_DROP;
      end
      ST_DONE: begin
        n_state = ST_IDLE;
        w_start = utmi_rx_active;
      end
      default: begin
        n_state = ST_IDLE;
      end
    endcase

    if (w_start) begin
      n_state = ST_PID;
      n_kind  = K_NONE;
      n_perr  = 1'b0;
      n_bcnt  = '0;
      n_crc5  = CRC5_INIT;
      n_crc16 = CRC16_INIT;
    end

    // A byte sampled together with the falling rx_active is folded in above.
    if (r_state inside {ST_PID, ST_TOKEN, ST_DATA, ST_HSHAKE, ST_DROP}
        && !utmi_rx_active) begin
      n_state = ST_DONE;
      w_eop   = 1'b1;
    end

    if (w_eop) begin
      unique case (1'b1)
        (n_kind == K_TOKEN):
          w_good = (n_bcnt == CW'(2)) && (n_crc5 == CRC5_RESID);
        (n_kind == K_DATA):
          w_good = (n_bcnt >= CW'(2)) && (n_crc16 == CRC16_RESID);
        (n_kind == K_HSHAKE):
          w_good = (n_bcnt == '0);
        default:
          w_good = 1'b0;
      endcase
      w_good   = w_good & ~n_perr;
      n_done   = 1'b1;
      n_crc_ok = w_good;
      n_err    = ~w_good;
      if (w_good && n_kind == K_TOKEN) begin
        n_token_valid = 1'b1;
        n_token       = {n_tok_hi, n_tok_lo};
      end
    end
  end

  usb_rx_holdback u_hb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_start),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_byte  (utmi_rx_data),
    .o_data  (w_hb_data),
    .o_valid (w_hb_valid),
    .o_count (w_hb_count)
  );

  assign rx_pid         = r_pid;
  assign rx_pid_valid   = r_pid_valid;
  assign rx_token       = r_token;
  assign rx_token_valid = r_token_valid;
  assign rx_data        = w_hb_data;
  assign rx_data_valid  = w_hb_valid;
  assign rx_data_count  = w_hb_count;
  assign rx_done        = r_done;
  assign rx_crc_ok      = r_crc_ok;
  assign rx_err         = r_err;

endmodule

// File: tb/tb_usb_rx_fsm.sv
// Directed bench for usb_rx_fsm: good/bad tokens, data, handshakes,
// PHY error, overflow, back-to-back packets and mid-packet reset.
module tb_usb_rx_fsm;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  utmi_rx_data = '0;
  logic        utmi_rx_valid = 1'b0;
  logic        utmi_rx_active = 1'b0;
  logic        utmi_rx_error = 1'b0;
  logic [3:0]  rx_pid;
  logic        rx_pid_valid;
  logic [10:0] rx_token;
  logic        rx_token_valid;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic [10:0] rx_data_count;
  logic        rx_done;
  logic        rx_crc_ok;
  logic        rx_err;

  always #5 clk = ~clk;

  usb_rx_fsm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .utmi_rx_data   (utmi_rx_data),
    .utmi_rx_valid  (utmi_rx_valid),
    .utmi_rx_active (utmi_rx_active),
    .utmi_rx_error  (utmi_rx_error),
    .rx_pid         (rx_pid),
    .rx_pid_valid   (rx_pid_valid),
    .rx_token       (rx_token),
    .rx_token_valid (rx_token_valid),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_data_count  (rx_data_count),
    .rx_done        (rx_done),
    .rx_crc_ok      (rx_crc_ok),
    .rx_err         (rx_err)
  );

  int n_chk = 0;
  int n_err = 0;
  int dv_cnt = 0, pidv_cnt = 0, done_cnt = 0;
  int ok_cnt = 0, bad_cnt = 0, tokv_cnt = 0;
  int b_dv, b_pidv, b_done, b_ok, b_bad, b_tokv;
  logic [7:0]  got [64];
  logic [10:0] last_count = '0;
  logic [10:0] last_tok = '0;
  bq_t pkt_q;

  always @(negedge clk) begin
    if (rx_data_valid) begin
      got[dv_cnt % 64] = rx_data;
      dv_cnt++;
    end
    if (rx_pid_valid) pidv_cnt++;
    if (rx_token_valid) begin
      tokv_cnt++;
      last_tok = rx_token;
    end
    if (rx_done) begin
      done_cnt++;
      if (rx_crc_ok) ok_cnt++;
      if (rx_err) bad_cnt++;
      last_count = rx_data_count;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_dv = dv_cnt;
    b_pidv = pidv_cnt;
    b_done = done_cnt;
    b_ok = ok_cnt;
    b_bad = bad_cnt;
    b_tokv = tokv_cnt;
  endtask

  task automatic send(input logic [7:0] b);
    utmi_rx_data = b;
    utmi_rx_valid = 1'b1;
    tick();
    utmi_rx_valid = 1'b0;
  endtask

  task automatic pkt(input bq_t q);
    snap();
    utmi_rx_active = 1'b1;
    tick();
    foreach (q[i]) send(q[i]);
    utmi_rx_active = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #3;
    chk("reset_outs", {rx_pid, rx_pid_valid, rx_token, rx_token_valid,
        rx_data, rx_data_valid, rx_data_count, rx_done, rx_crc_ok,
        rx_err}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    pkt_q = '{8'h2D, 8'h00, 8'h10};
    pkt(pkt_q);
    chk("setup_done", done_cnt - b_done, 1);
    chk("setup_pidv", pidv_cnt - b_pidv, 1);
    chk("setup_pid", rx_pid, 4'hD);
    chk("setup_tokv", tokv_cnt - b_tokv, 1);
    chk("setup_tok", last_tok, 11'h000);
    chk("setup_ok", ok_cnt - b_ok, 1);

    pkt_q = '{8'h69, 8'h01, 8'hE8};
    pkt(pkt_q);
    chk("in_pid", rx_pid, 4'h9);
    chk("in_tokv", tokv_cnt - b_tokv, 1);
    chk("in_tok", last_tok, 11'h001);
    chk("in_ok", ok_cnt - b_ok, 1);

    pkt_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00,
              8'h40, 8'h00, 8'hDD, 8'h94};
    pkt(pkt_q);
    chk("d0_dv", dv_cnt - b_dv, 8);
    chk("d0_b0", got[(b_dv + 0) % 64], 8'h80);
    chk("d0_b1", got[(b_dv + 1) % 64], 8'h06);
    chk("d0_b3", got[(b_dv + 3) % 64], 8'h01);
    chk("d0_b6", got[(b_dv + 6) % 64], 8'h40);
    chk("d0_b7", got[(b_dv + 7) % 64], 8'h00);
    chk("d0_count", last_count, 11'd8);
    chk("d0_ok", ok_cnt - b_ok, 1);
    chk("d0_tokv", tokv_cnt - b_tokv, 0);

    pkt_q = '{8'h4B, 8'h00, 8'h00};
    pkt(pkt_q);
    chk("zlp_dv", dv_cnt - b_dv, 0);
    chk("zlp_ok", ok_cnt - b_ok, 1);
    chk("zlp_count", last_count, 11'd0);

    pkt_q = '{8'hD2};
    pkt(pkt_q);
    chk("ack_pid", rx_pid, 4'h2);
    chk("ack_ok", ok_cnt - b_ok, 1);

    pkt_q = '{8'h2C};
    pkt(pkt_q);
    chk("badpid_pidv", pidv_cnt - b_pidv, 0);
    chk("badpid_err", bad_cnt - b_bad, 1);
    chk("badpid_pid_held", rx_pid, 4'h2);

    pkt_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00,
              8'h40, 8'h00, 8'hDD, 8'h95};
    pkt(pkt_q);
    chk("crc16_err", bad_cnt - b_bad, 1);
    chk("crc16_ok0", ok_cnt - b_ok, 0);
    chk("err_held", {rx_crc_ok, rx_err}, 2'b01);

    pkt_q = '{8'h2D, 8'h00, 8'h11};
    pkt(pkt_q);
    chk("crc5_err", bad_cnt - b_bad, 1);
    chk("crc5_tokv", tokv_cnt - b_tokv, 0);

    pkt_q = '{8'hD2, 8'h00};
    pkt(pkt_q);
    chk("hs_extra_err", bad_cnt - b_bad, 1);

    snap();
    utmi_rx_active = 1'b1;
    tick();
    utmi_rx_active = 1'b0;
    repeat (3) tick();
    chk("nopid_done", done_cnt - b_done, 1);
    chk("nopid_err", bad_cnt - b_bad, 1);
    chk("nopid_pidv", pidv_cnt - b_pidv, 0);

    snap();
    utmi_rx_active = 1'b1;
    tick();
    send(8'h4B);
    send(8'h00);
    utmi_rx_data = 8'h00;
    utmi_rx_valid = 1'b1;
    utmi_rx_active = 1'b0;
    tick();
    utmi_rx_valid = 1'b0;
    repeat (2) tick();
    chk("simul_eop_ok", ok_cnt - b_ok, 1);

    snap();
    utmi_rx_active = 1'b1;
    tick();
    send(8'hC3);
    send(8'h80);
    send(8'h06);
    send(8'h00);
    utmi_rx_data = 8'h01;
    utmi_rx_valid = 1'b1;
    utmi_rx_error = 1'b1;
    tick();
    utmi_rx_valid = 1'b0;
    utmi_rx_error = 1'b0;
    send(8'h00);
    send(8'h40);
    utmi_rx_active = 1'b0;
    repeat (3) tick();
    chk("phyerr_dv", dv_cnt - b_dv, 1);
    chk("phyerr_b0", got[b_dv % 64], 8'h80);
    chk("phyerr_err", bad_cnt - b_bad, 1);

    snap();
    utmi_rx_active = 1'b1;
    tick();
    send(8'hC3);
    repeat (1027) send(8'h00);
    utmi_rx_active = 1'b0;
    repeat (3) tick();
    chk("ovf_dv", dv_cnt - b_dv, 1024);
    chk("ovf_err", bad_cnt - b_bad, 1);
    chk("ovf_count", last_count, 11'd1024);

    snap();
    utmi_rx_active = 1'b1;
    tick();
    send(8'h2D);
    send(8'h00);
    send(8'h10);
    utmi_rx_active = 1'b0;
    tick();
    utmi_rx_active = 1'b1;
    tick();
    send(8'hC3);
    send(8'h00);
    send(8'h00);
    utmi_rx_active = 1'b0;
    repeat (3) tick();
    chk("b2b_done", done_cnt - b_done, 2);
    chk("b2b_ok", ok_cnt - b_ok, 2);
    chk("b2b_pid", rx_pid, 4'h3);

    utmi_rx_active = 1'b1;
    tick();
    send(8'hC3);
    send(8'h80);
    send(8'h06);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {rx_pid, rx_pid_valid, rx_token, rx_token_valid,
        rx_data, rx_data_valid, rx_data_count, rx_done, rx_crc_ok,
        rx_err}, 64'd0);
    tick();
    rst_n = 1'b1;
    snap();
    send(8'hC3);
    send(8'h00);
    send(8'h00);
    utmi_rx_active = 1'b0;
    repeat (3) tick();
    chk("midrst_ignored", done_cnt - b_done, 0);
    chk("midrst_pidv", pidv_cnt - b_pidv, 0);

    pkt_q = '{8'h2D, 8'h00, 8'h10};
    pkt(pkt_q);
    chk("after_rst_ok", ok_cnt - b_ok, 1);
    chk("after_rst_pid", rx_pid, 4'hD);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
